rgb_pwm_multi: RTL

Parametrised N-channel PWM generator for RGB and other LED drives.
- One shared prescaled period counter; per-channel duty cycle with DUTY_W-bit resolution.
- Duty updates are double-buffered and commit only at period wrap, so outputs never glitch mid-period.
- Per-channel mode is either static duty or "breathe" (a triangle ramp between 0 and the programmed duty).
- Sits between the colour/alarm logic and the board LED pins.

---
 rtl/rgb_pwm_pkg.sv | 14 +
 rtl/rgb_pwm_chan.sv | 101 ++++++++++
 rtl/rgb_pwm_multi.sv | 78 +++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the multi-channel RGB PWM generator.
package rgb_pwm_pkg;

    typedef enum logic {
        PWM_STATIC  = 1'b0,
        PWM_BREATHE = 1'b1
    } pwm_mode_e;

    // Last counter value of a period; a period spans 2^dw-1 ticks.
    function automatic int cnt_max(input int dw);
        return (1 << dw) - 2;
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: double-buffered duty/mode, breathe ramp and the registered
// compare output.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int DUTY_W      = 4,
    parameter int BREATH_STEP = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic              wrap_i,
    input  logic              wr_sel_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  logic              wr_mode_i,
    output logic              dirty_o,
    output logic              pwm_o
);
    localparam logic [DUTY_W:0] STEP = (DUTY_W+1)'(BREATH_STEP);
    localparam logic            INV  = (ACTIVE_LOW != 0);

    function automatic logic [DUTY_W-1:0] ramp_up(input logic [DUTY_W-1:0] lvl,
                                                  input logic [DUTY_W-1:0] lim);
        logic [DUTY_W:0] sum;
        sum = {1'b0, lvl} + STEP;
        return (sum > {1'b0, lim}) ? lim : sum[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] ramp_down(input logic [DUTY_W-1:0] lvl);
        logic [DUTY_W:0] diff;
        diff = {1'b0, lvl} - STEP;
        return ({1'b0, lvl} < STEP) ? '0 : diff[DUTY_W-1:0];
    endfunction

    pwm_mode_e         pend_mode_q, act_mode_q, mode_post;
    logic [DUTY_W-1:0] pend_duty_q, act_duty_q, duty_post;
    logic [DUTY_W-1:0] level_q, level_d, lvl_base, eff;
    logic              dir_down_q, dir_down_d, dir_base;
    logic              dirty_q, dirty_d;
    logic              pwm_q, pwm_d;

    always_comb begin
        duty_post  = dirty_q ? pend_duty_q : act_duty_q;
        mode_post  = dirty_q ? pend_mode_q : act_mode_q;
        level_d    = level_q;
        dir_down_d = dir_down_q;
        lvl_base   = level_q;
        dir_base   = dir_down_q;
        if (wrap_i && mode_post == PWM_BREATHE) begin
            // Entering breathe from static restarts the ramp from zero.
            if (dirty_q && act_mode_q == PWM_STATIC) begin
                lvl_base = '0;
                dir_base = 1'b0;
            end
            if (lvl_base > duty_post) begin
                level_d    = duty_post;
                dir_down_d = 1'b1;
            end else if (!dir_base) begin
                level_d    = ramp_up(lvl_base, duty_post);
                dir_down_d = (level_d == duty_post);
            end else begin
                level_d    = ramp_down(lvl_base);
                dir_down_d = (level_d != '0);
            end
        end
        eff     = (act_mode_q == PWM_BREATHE) ? level_q : act_duty_q;
        pwm_d   = (cnt_i < eff) ^ INV;
        dirty_d = wr_sel_i | (dirty_q & ~wrap_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_duty_q <= '0;
            pend_mode_q <= PWM_STATIC;
            act_duty_q  <= '0;
            act_mode_q  <= PWM_STATIC;
            level_q     <= '0;
            dir_down_q  <= 1'b0;
            dirty_q     <= 1'b0;
            pwm_q       <= INV;
        end else begin
            if (wrap_i && dirty_q) begin
                act_duty_q <= pend_duty_q;
                act_mode_q <= pend_mode_q;
            end
            if (wr_sel_i) begin
                pend_duty_q <= wr_duty_i;
                pend_mode_q <= pwm_mode_e'(wr_mode_i);
            end
            dirty_q    <= dirty_d;
            level_q    <= level_d;
            dir_down_q <= dir_down_d;
            pwm_q      <= pwm_d;
        end
    end

    assign dirty_o = dirty_q;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/rgb_pwm_multi.sv
// N-channel PWM top: prescaler, shared period counter, write decode and the
// period_start/commit pulses; per-channel state lives in rgb_pwm_chan.
module rgb_pwm_multi
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DUTY_W      = 4,
    parameter int PRESC       = 1,
    parameter int BREATH_STEP = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [DUTY_W-1:0]                           wr_duty,
    input  logic                                        wr_mode,
    output logic [NUM_CH-1:0]                           pwm_out,
    output logic                                        period_start,
    output logic                                        commit
);
    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                PW      = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(cnt_max(DUTY_W));

    logic [PW-1:0]     presc_q, presc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              period_start_q, commit_q;
    logic              tick, wrap;
    logic [NUM_CH-1:0] dirty;

    always_comb begin
        tick    = (presc_q == PW'(PRESC - 1));
        wrap    = tick && (cnt_q == CNT_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + DUTY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            commit_q       <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            period_start_q <= wrap;
            // Channels written in the wrap cycle are not yet dirty here.
            commit_q       <= wrap && (|dirty);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_pwm_chan #(
            .DUTY_W      (DUTY_W),
            .BREATH_STEP (BREATH_STEP),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .cnt_i     (cnt_q),
            .wrap_i    (wrap),
            .wr_sel_i  (wr_en && (wr_ch == CH_W'(c))),
            .wr_duty_i (wr_duty),
            .wr_mode_i (wr_mode),
            .dirty_o   (dirty[c]),
            .pwm_o     (pwm_out[c])
        );
    end

    assign period_start = period_start_q;
    assign commit       = commit_q;

endmodule
